// File: rtl/up_initiator_pkg.sv
// Shared types for the uP command initiator: FSM state encoding and the
// queued command record carried through the command FIFO.
package up_initiator_pkg;

    localparam int unsigned CMD_ADDR_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // addr is stored at its widest so one record serves every ADDR_WIDTH
    typedef struct packed {
        logic                    write;
        logic [CMD_ADDR_MAX-1:0] addr;
        logic [31:0]             wdata;
    } cmd_t;

    function automatic cmd_t cmd_pack(
        input logic                    write,
        input logic [CMD_ADDR_MAX-1:0] addr,
        input logic [31:0]             wdata
    );
        cmd_t c;
        c.write = write;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/up_cmd_fifo.sv
// Synchronous show-ahead command FIFO; head is valid whenever empty is low.
// Pushes while full and pops while empty are dropped internally.
module up_cmd_fifo
    import up_initiator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_r;
    logic [PW:0] rd_ptr_r;
    cmd_t        mem_r [DEPTH];
    logic        push_ok_s;
    logic        pop_ok_s;

    // Extra pointer MSB distinguishes full from empty when indices match
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[PW-1:0]];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= push_data;
        end
    end

    // Read/write pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/up_cmd_initiator.sv
// Queues register read/write commands and plays them one at a time onto the
// uP request bus, waiting for a matching ack or a timeout before responding.
module up_cmd_initiator
    import up_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  up_clk,
    input  logic                  up_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  up_wreq,
    output logic [ADDR_WIDTH-1:0] up_waddr,
    output logic [31:0]           up_wdata,
    input  logic                  up_wack,
    output logic                  up_rreq,
    output logic [ADDR_WIDTH-1:0] up_raddr,
    input  logic [31:0]           up_rdata,
    input  logic                  up_rack,
    output logic                  busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  cur_write_r, cur_write_s;
    logic                  wreq_r, wreq_s;
    logic                  rreq_r, rreq_s;
    logic [ADDR_WIDTH-1:0] waddr_r, waddr_s;
    logic [31:0]           wdata_r, wdata_s;
    logic [ADDR_WIDTH-1:0] raddr_r, raddr_s;
    logic                  rsp_valid_r, rsp_valid_s;
    logic                  rsp_write_r, rsp_write_s;
    logic [31:0]           rsp_rdata_r, rsp_rdata_s;
    logic                  rsp_timeout_r, rsp_timeout_s;
    logic                  ack_hit_s;
    logic                  pop_s;
    cmd_t                  head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    up_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (up_clk),
        .rst       (up_rst),
        .push      (cmd_valid),
        .push_data (cmd_pack(cmd_write, CMD_ADDR_MAX'(cmd_addr), cmd_wdata)),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign cmd_ready   = !fifo_full_s;
    assign busy        = (state_r != ST_IDLE) || !fifo_empty_s;
    assign up_wreq     = wreq_r;
    assign up_waddr    = waddr_r;
    assign up_wdata    = wdata_r;
    assign up_rreq     = rreq_r;
    assign up_raddr    = raddr_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_write   = rsp_write_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_timeout = rsp_timeout_r;

    // Next-state and next-output logic; request strobes are one-cycle pulses
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        cur_write_s   = cur_write_r;
        wreq_s        = 1'b0;
        rreq_s        = 1'b0;
        waddr_s       = waddr_r;
        wdata_s       = wdata_r;
        raddr_s       = raddr_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_write_s   = rsp_write_r;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_timeout_s = rsp_timeout_r;
        pop_s         = 1'b0;
        ack_hit_s     = cur_write_r ? up_wack : up_rack;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_s     = ST_ISSUE;
                    cur_write_s = head_s.write;
                    if (head_s.write) begin
                        wreq_s  = 1'b1;
                        waddr_s = ADDR_WIDTH'(head_s.addr);
                        wdata_s = head_s.wdata;
                    end else begin
                        rreq_s  = 1'b1;
                        raddr_s = ADDR_WIDTH'(head_s.addr);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
                cnt_s   = '0;
            end
            ST_WAIT: begin
                // A matching ack on the final counted cycle still beats the timeout
                if (ack_hit_s) begin
                    state_s       = ST_RESP;
                    rsp_valid_s   = 1'b1;
                    rsp_write_s   = cur_write_r;
                    rsp_rdata_s   = cur_write_r ? 32'h0000_0000 : up_rdata;
                    rsp_timeout_s = 1'b0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s       = ST_RESP;
                    rsp_valid_s   = 1'b1;
                    rsp_write_s   = cur_write_r;
                    rsp_rdata_s   = 32'h0000_0000;
                    rsp_timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s       = ST_IDLE;
                    rsp_valid_s   = 1'b0;
                    rsp_write_s   = 1'b0;
                    rsp_rdata_s   = 32'h0000_0000;
                    rsp_timeout_s = 1'b0;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered output bank
    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            cur_write_r   <= 1'b0;
            wreq_r        <= 1'b0;
            rreq_r        <= 1'b0;
            waddr_r       <= '0;
            wdata_r       <= 32'h0000_0000;
            raddr_r       <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_write_r   <= 1'b0;
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            cur_write_r   <= cur_write_s;
            wreq_r        <= wreq_s;
            rreq_r        <= rreq_s;
            waddr_r       <= waddr_s;
            wdata_r       <= wdata_s;
            raddr_r       <= raddr_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_write_r   <= rsp_write_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

endmodule

// File: tb/tb_up_cmd_initiator.sv
// Directed self-checking bench for up_cmd_initiator (ADDR_WIDTH=8, FIFO_DEPTH=4,
// TIMEOUT_CYCLES=8); inputs change 1 time unit after the rising edge.
module tb_up_cmd_initiator;

    logic        up_clk = 1'b0;
    logic        up_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        up_wreq;
    logic [7:0]  up_waddr;
    logic [31:0] up_wdata;
    logic        up_wack = 1'b0;
    logic        up_rreq;
    logic [7:0]  up_raddr;
    logic [31:0] up_rdata = 32'h0;
    logic        up_rack = 1'b0;
    logic        busy;

    int checks = 0;
    int passes = 0;

    up_cmd_initiator #(.ADDR_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .up_clk(up_clk), .up_rst(up_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .busy(busy)
    );

    always #5 up_clk = ~up_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge up_clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        up_rst = 1'b1;
        repeat (3) tick();
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passes++;
        checks++; if ({up_wreq, up_rreq} !== 2'b00) $display("FAIL rst_reqs: got %b want 00", {up_wreq, up_rreq}); else passes++;
        checks++; if (up_waddr !== 8'h00) $display("FAIL rst_waddr: got %h want 00", up_waddr); else passes++;
        up_rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        push(1'b1, 8'h04, 32'hDEADBEEF);
        checks++; if (busy !== 1'b1) $display("FAIL wr_busy_queued: got %0b want 1", busy); else passes++;
        checks++; if (up_wreq !== 1'b0) $display("FAIL wr_req_early: got %0b want 0", up_wreq); else passes++;
        tick();
        checks++; if (up_wreq !== 1'b1) $display("FAIL wr_req: got %0b want 1", up_wreq); else passes++;
        checks++; if (up_rreq !== 1'b0) $display("FAIL wr_no_rreq: got %0b want 0", up_rreq); else passes++;
        checks++; if (up_waddr !== 8'h04) $display("FAIL wr_addr: got %h want 04", up_waddr); else passes++;
        checks++; if (up_wdata !== 32'hDEADBEEF) $display("FAIL wr_data: got %h want deadbeef", up_wdata); else passes++;
        tick();
        up_wack = 1'b1;
        checks++; if (up_wreq !== 1'b0) $display("FAIL wr_req_one_cycle: got %0b want 0", up_wreq); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_early: got %0b want 0", rsp_valid); else passes++;
        tick();
        up_wack = 1'b0;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid: got %0b want 1", rsp_valid); else passes++;
        checks++; if (rsp_write !== 1'b1) $display("FAIL wr_rsp_write: got %0b want 1", rsp_write); else passes++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata: got %h want 0", rsp_rdata); else passes++;
        checks++; if (rsp_timeout !== 1'b0) $display("FAIL wr_rsp_timeout: got %0b want 0", rsp_timeout); else passes++;
        tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL wr_rsp_hold: got %0b want 1", rsp_valid); else passes++;
        consume();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_drop: got %0b want 0", rsp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL wr_idle_busy: got %0b want 0", busy); else passes++;
    endtask

    task automatic test_read();
        push(1'b0, 8'h02, 32'hFFFFFFFF);
        tick();
        checks++; if (up_rreq !== 1'b1) $display("FAIL rd_req: got %0b want 1", up_rreq); else passes++;
        checks++; if (up_wreq !== 1'b0) $display("FAIL rd_no_wreq: got %0b want 0", up_wreq); else passes++;
        checks++; if (up_raddr !== 8'h02) $display("FAIL rd_addr: got %h want 02", up_raddr); else passes++;
        checks++; if (up_waddr !== 8'h04) $display("FAIL rd_waddr_hold: got %h want 04", up_waddr); else passes++;
        tick();
        up_rack = 1'b1; up_rdata = 32'h12345678;
        tick();
        up_rack = 1'b0; up_rdata = 32'h0;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %0b want 1", rsp_valid); else passes++;
        checks++; if (rsp_rdata !== 32'h12345678) $display("FAIL rd_rsp_rdata: got %h want 12345678", rsp_rdata); else passes++;
        checks++; if (rsp_write !== 1'b0) $display("FAIL rd_rsp_write: got %0b want 0", rsp_write); else passes++;
        checks++; if (rsp_timeout !== 1'b0) $display("FAIL rd_rsp_timeout: got %0b want 0", rsp_timeout); else passes++;
        consume();
        checks++; if (up_raddr !== 8'h02) $display("FAIL rd_raddr_hold: got %h want 02", up_raddr); else passes++;
    endtask

    task automatic test_timeout();
        bit early = 1'b0;
        push(1'b0, 8'h33, 32'h0);
        tick();
        checks++; if (up_rreq !== 1'b1) $display("FAIL to_req: got %0b want 1", up_rreq); else passes++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        checks++; if (early !== 1'b0) $display("FAIL to_no_early_rsp: got %0b want 0", early); else passes++;
        tick();
        checks++; if (rsp_valid !== 1'b1) $display("FAIL to_rsp_valid: got %0b want 1", rsp_valid); else passes++;
        checks++; if (rsp_timeout !== 1'b1) $display("FAIL to_rsp_timeout: got %0b want 1", rsp_timeout); else passes++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL to_rsp_rdata: got %h want 0", rsp_rdata); else passes++;
        checks++; if (rsp_write !== 1'b0) $display("FAIL to_rsp_write: got %0b want 0", rsp_write); else passes++;
        consume();
    endtask

    task automatic test_timeout_boundary();
        push(1'b0, 8'h44, 32'h0);
        tick();
        repeat (8) tick();
        up_rack = 1'b1; up_rdata = 32'hA5A50001;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL tb_rsp_early: got %0b want 0", rsp_valid); else passes++;
        tick();
        up_rack = 1'b0; up_rdata = 32'h0;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL tb_rsp_valid: got %0b want 1", rsp_valid); else passes++;
        checks++; if (rsp_timeout !== 1'b0) $display("FAIL tb_ack_wins: got %0b want 0", rsp_timeout); else passes++;
        checks++; if (rsp_rdata !== 32'hA5A50001) $display("FAIL tb_rsp_rdata: got %h want a5a50001", rsp_rdata); else passes++;
        consume();
    endtask

    task automatic test_stray_ack();
        up_wack = 1'b1; up_rack = 1'b1;
        tick(); tick();
        up_wack = 1'b0; up_rack = 1'b0;
        checks++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL st_idle_ack: got %b want 00", {busy, rsp_valid}); else passes++;
        push(1'b1, 8'h10, 32'h0BADF00D);
        tick();
        checks++; if (up_wreq !== 1'b1) $display("FAIL st_req: got %0b want 1", up_wreq); else passes++;
        up_wack = 1'b1;
        tick();
        up_wack = 1'b0; up_rack = 1'b1; up_rdata = 32'hFFFF0000;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL st_issue_ack: got %0b want 0", rsp_valid); else passes++;
        repeat (3) tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL st_rack_on_write: got %0b want 0", rsp_valid); else passes++;
        up_rack = 1'b0; up_rdata = 32'h0; up_wack = 1'b1;
        tick();
        up_wack = 1'b0;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL st_rsp_valid: got %0b want 1", rsp_valid); else passes++;
        checks++; if ({rsp_write, rsp_timeout} !== 2'b10) $display("FAIL st_rsp_flags: got %b want 10", {rsp_write, rsp_timeout}); else passes++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL st_rsp_rdata: got %h want 0", rsp_rdata); else passes++;
        consume();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        push(1'b1, 8'h20, 32'h11112222);
        push(1'b0, 8'h21, 32'h0);
        checks++; if (up_wreq !== 1'b1) $display("FAIL bb_wreq: got %0b want 1", up_wreq); else passes++;
        tick();
        up_wack = 1'b1;
        tick();
        up_wack = 1'b0;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL bb_rsp1: got %0b want 1", rsp_valid); else passes++;
        tick();
        checks++; if ({rsp_valid, up_rreq} !== 2'b00) $display("FAIL bb_gap: got %b want 00", {rsp_valid, up_rreq}); else passes++;
        tick();
        checks++; if (up_rreq !== 1'b1) $display("FAIL bb_rreq_at_plus2: got %0b want 1", up_rreq); else passes++;
        checks++; if (up_raddr !== 8'h21) $display("FAIL bb_raddr: got %h want 21", up_raddr); else passes++;
        tick();
        up_rack = 1'b1; up_rdata = 32'hCAFEF00D;
        tick();
        up_rack = 1'b0; up_rdata = 32'h0;
        checks++; if (rsp_rdata !== 32'hCAFEF00D) $display("FAIL bb_rdata: got %h want cafef00d", rsp_rdata); else passes++;
        tick();
        rsp_ready = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL bb_busy: got %0b want 0", busy); else passes++;
    endtask

    task automatic test_fifo_full();
        logic        exp_w [5];
        logic [7:0]  exp_a [5];
        logic [31:0] exp_d [5];
        int          w;
        exp_w[0] = 1'b1; exp_a[0] = 8'h50; exp_d[0] = 32'hA0A0A0A0;
        exp_w[1] = 1'b0; exp_a[1] = 8'h51; exp_d[1] = 32'h0;
        exp_w[2] = 1'b1; exp_a[2] = 8'h52; exp_d[2] = 32'hC0C0C0C0;
        exp_w[3] = 1'b0; exp_a[3] = 8'h53; exp_d[3] = 32'h0;
        exp_w[4] = 1'b1; exp_a[4] = 8'h54; exp_d[4] = 32'hE0E0E0E0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_write = exp_w[i]; cmd_addr = exp_a[i]; cmd_wdata = exp_d[i];
            w = 0;
            while (cmd_ready !== 1'b1 && w < 10) begin tick(); w++; end
            checks++; if (w >= 10) $display("FAIL ff_push_ready[%0d]: got 0 want 1", i); else passes++;
            tick();
        end
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL ff_full_ready: got %0b want 0", cmd_ready); else passes++;
        checks++; if (up_waddr !== 8'h50) $display("FAIL ff_first_issued: got %h want 50", up_waddr); else passes++;
        w = 0;
        while (rsp_valid !== 1'b1 && w < 30) begin tick(); w++; end
        checks++; if (w >= 30) $display("FAIL ff_first_rsp_wait: got 0 want 1"); else passes++;
        checks++; if ({rsp_write, rsp_timeout} !== 2'b11) $display("FAIL ff_first_timeout: got %b want 11", {rsp_write, rsp_timeout}); else passes++;
        consume();
        for (int i = 1; i < 5; i++) begin
            w = 0;
            while (up_wreq !== 1'b1 && up_rreq !== 1'b1 && w < 10) begin tick(); w++; end
            checks++; if (w >= 10) $display("FAIL ff_req_wait[%0d]: got none want request", i); else passes++;
            checks++; if (up_wreq !== exp_w[i]) $display("FAIL ff_order_type[%0d]: got %0b want %0b", i, up_wreq, exp_w[i]); else passes++;
            checks++; if ((exp_w[i] ? up_waddr : up_raddr) !== exp_a[i]) $display("FAIL ff_order_addr[%0d]: got %h/%h want %h", i, up_waddr, up_raddr, exp_a[i]); else passes++;
            tick();
            if (exp_w[i]) up_wack = 1'b1;
            else begin up_rack = 1'b1; up_rdata = {24'h5A5A00, exp_a[i]}; end
            tick();
            up_wack = 1'b0; up_rack = 1'b0; up_rdata = 32'h0;
            checks++; if (rsp_valid !== 1'b1) $display("FAIL ff_rsp_valid[%0d]: got %0b want 1", i, rsp_valid); else passes++;
            checks++; if (rsp_rdata !== (exp_w[i] ? 32'h0 : {24'h5A5A00, exp_a[i]})) $display("FAIL ff_rsp_rdata[%0d]: got %h", i, rsp_rdata); else passes++;
            consume();
        end
        checks++; if ({busy, cmd_ready} !== 2'b01) $display("FAIL ff_drained: got %b want 01", {busy, cmd_ready}); else passes++;
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        push(1'b1, 8'h60, 32'h66666666);
        tick();
        tick();
        up_rst = 1'b1;
        #1;
        checks++; if ({busy, rsp_valid, up_wreq, cmd_ready} !== 4'b0001) $display("FAIL rm_async: got %b want 0001", {busy, rsp_valid, up_wreq, cmd_ready}); else passes++;
        checks++; if (up_waddr !== 8'h00) $display("FAIL rm_waddr: got %h want 00", up_waddr); else passes++;
        tick();
        up_rst = 1'b0;
        tick();
        up_wack = 1'b1; up_rack = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) begin up_wack = 1'b0; up_rack = 1'b0; end
            tick();
            if ({rsp_valid, busy, up_wreq, up_rreq} !== 4'b0000) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) $display("FAIL rm_late_ack: got %0b want 0", bad); else passes++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_timeout_boundary();
        test_stray_ack();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
